// File: rtl/fir_decim_buffer_pkg.sv
// Shared types and width helpers for the FIR output path.
package fir_decim_buffer_pkg;

    localparam int unsigned SAMPLE_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // FIFO operation for one cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Pointer / counter width able to index n entries (at least 1 bit)
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy width able to hold 0..depth inclusive
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Sample-in / stream-out bundle of the decimating output buffer.
interface fir_decim_buffer_if
    import fir_decim_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH = 8
);

    logic                          en;
    logic signed [WIDTH-1:0]       data_in;
    logic                          clear;
    logic                          out_valid;
    logic signed [WIDTH-1:0]       out_data;
    logic                          out_ready;
    logic [level_w(DEPTH)-1:0]     level;
    logic                          overflow;

    // Producer / consumer side (filter + sink)
    modport master (
        output en, data_in, clear, out_ready,
        input  out_valid, out_data, level, overflow
    );

    // Buffer side
    modport slave (
        input  en, data_in, clear, out_ready,
        output out_valid, out_data, level, overflow
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with registered show-ahead head and exact occupancy.
module fir_sync_fifo
    import fir_decim_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic signed [WIDTH-1:0]   push_data_i,
    input  logic                      pop_i,
    output logic signed [WIDTH-1:0]   head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d, rd_next;
    logic [LW-1:0]           level_q, level_d;
    logic signed [WIDTH-1:0] head_q, head_d;
    logic                    full, empty, push_ok, pop_ok;
    fifo_op_e                op;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign pop_ok  = pop_i && !empty;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push_ok = push_i && (!full || pop_ok);
    assign op      = fifo_op_e'({push_ok, pop_ok});
    assign rd_next = rd_ptr_q + PW'(1);

    // Next pointers, occupancy and head; head is a register so it holds the
    // last popped value when the FIFO drains and is never read from an
    // unwritten slot
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            unique case (op)
                FIFO_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    level_d  = level_q + LW'(1);
                    if (empty) head_d = push_data_i;
                end
                FIFO_POP: begin
                    rd_ptr_d = rd_next;
                    level_d  = level_q - LW'(1);
                    if (level_q != LW'(1)) head_d = mem_q[rd_next];
                end
                FIFO_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_next;
                    head_d   = (level_q == LW'(1)) ? push_data_i : mem_q[rd_next];
                end
                default: ;
            endcase
        end
    end

    // Storage write at the tail
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign level_o = level_q;

endmodule

// File: rtl/fir_decim_buffer.sv
// Keeps one of every DECIM filter samples and queues them as a valid/ready stream.
module fir_decim_buffer
    import fir_decim_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DECIM = 4,
    parameter int unsigned PHASE = 0,
    parameter int unsigned DEPTH = 8
) (
    input logic               clk,
    input logic               rst_b,
    fir_decim_buffer_if.slave bus
);

    localparam int unsigned PHW = ptr_w(DECIM);
    localparam int unsigned LW  = level_w(DEPTH);

    logic [PHW-1:0]          phase_q, phase_d;
    logic                    overflow_q, overflow_d;
    logic                    keep, push_req, pop, full, empty;
    logic signed [WIDTH-1:0] head;
    logic [LW-1:0]           level;

    assign keep     = bus.en && (phase_q == PHW'(PHASE));
    assign push_req = keep && !bus.clear;
    assign pop      = !empty && bus.out_ready && !bus.clear;

    // Phase advances only on sample strobes; clear restarts it
    always_comb begin
        phase_d = phase_q;
        if (bus.clear)
            phase_d = '0;
        else if (bus.en)
            phase_d = (phase_q == PHW'(DECIM - 1)) ? '0 : phase_q + PHW'(1);
    end

    // Sticky drop flag: kept sample arriving with no slot free this cycle
    always_comb begin
        overflow_d = overflow_q | (push_req && full && !pop);
        if (bus.clear) overflow_d = 1'b0;
    end

    // Phase and overflow registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_b       (rst_b),
        .clear_i     (bus.clear),
        .push_i      (push_req),
        .push_data_i (bus.data_in),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head;
    assign bus.level     = level;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer: PHASE=0 and PHASE=2 instances, DECIM=4, DEPTH=8.
module tb_fir_decim_buffer;
    import fir_decim_buffer_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = level_w(DEPTH);

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    int   vecs  = 0;
    int   errs  = 0;

    fir_decim_buffer_if #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) b0 ();
    fir_decim_buffer_if #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) b2 ();

    fir_decim_buffer #(.WIDTH(SAMPLE_W), .DECIM(4), .PHASE(0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_b(rst_b), .bus(b0.slave));
    fir_decim_buffer #(.WIDTH(SAMPLE_W), .DECIM(4), .PHASE(2), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_b(rst_b), .bus(b2.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic en, input sample_t d, input logic rdy, input logic clr);
        b0.en = en; b0.data_in = d; b0.out_ready = rdy; b0.clear = clr;
    endtask

    task automatic drv2(input logic en, input sample_t d, input logic rdy, input logic clr);
        b2.en = en; b2.data_in = d; b2.out_ready = rdy; b2.clear = clr;
    endtask

    task automatic test_reset();
        drv0(1'b0, '0, 1'b0, 1'b0);
        drv2(1'b0, '0, 1'b0, 1'b0);
        rst_b = 1'b0;
        #12;
        vecs++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b expected 0", b0.out_valid); end
        vecs++; if (b0.out_data !== sample_t'(0)) begin errs++; $display("FAIL reset_data got %0d expected 0", b0.out_data); end
        vecs++; if (b0.level !== LW'(0)) begin errs++; $display("FAIL reset_level got %0d expected 0", b0.level); end
        vecs++; if (b0.overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow got %b expected 0", b0.overflow); end
        vecs++; if (b2.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid_p2 got %b expected 0", b2.out_valid); end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // PHASE=0, en every cycle: samples 0,4,8,12 emitted for one cycle each
    task automatic test_decimate();
        logic exp_v;
        for (int k = 0; k < 16; k++) begin
            drv0(1'b1, sample_t'(k), 1'b1, 1'b0);
            tick();
            exp_v = (k % 4 == 0);
            vecs++; if (b0.out_valid !== exp_v) begin errs++; $display("FAIL dec_valid k=%0d got %b expected %b", k, b0.out_valid, exp_v); end
            if (exp_v) begin
                vecs++; if (b0.out_data !== sample_t'(k)) begin errs++; $display("FAIL dec_data k=%0d got %0d expected %0d", k, b0.out_data, k); end
            end
        end
        drv0(1'b0, '0, 1'b1, 1'b0);
        tick();
        vecs++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL dec_drained got %b expected 0", b0.out_valid); end
        vecs++; if (b0.overflow !== 1'b0) begin errs++; $display("FAIL dec_overflow got %b expected 0", b0.overflow); end
    endtask

    // PHASE=2, en on every 3rd cycle: only the 3rd, 7th, 11th strobes (cycles 8,20,32) kept
    task automatic test_sparse_en();
        logic en, exp_v;
        int   seen;
        seen = 0;
        for (int c = 0; c < 36; c++) begin
            en = (c % 3 == 2);
            drv2(en, sample_t'(c), 1'b1, 1'b0);
            tick();
            exp_v = (c == 8) || (c == 20) || (c == 32);
            if (b2.out_valid === 1'b1) seen++;
            vecs++; if (b2.out_valid !== exp_v) begin errs++; $display("FAIL sparse_valid c=%0d got %b expected %b", c, b2.out_valid, exp_v); end
            if (exp_v) begin
                vecs++; if (b2.out_data !== sample_t'(c)) begin errs++; $display("FAIL sparse_data c=%0d got %0d expected %0d", c, b2.out_data, c); end
            end
        end
        vecs++; if (seen != 3) begin errs++; $display("FAIL sparse_count got %0d expected 3", seen); end
        drv2(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Stalled consumer: 9 kept samples into 8 slots, then drain in order
    task automatic test_overflow();
        for (int k = 0; k < 9; k++) begin
            drv0(1'b1, sample_t'(k - 128), 1'b0, 1'b0);
            tick();
            if (k < 8) begin
                vecs++; if (b0.level !== LW'(k + 1)) begin errs++; $display("FAIL ovf_level k=%0d got %0d expected %0d", k, b0.level, k + 1); end
                vecs++; if (b0.overflow !== 1'b0) begin errs++; $display("FAIL ovf_early k=%0d got %b expected 0", k, b0.overflow); end
            end else begin
                vecs++; if (b0.level !== LW'(8)) begin errs++; $display("FAIL ovf_level_full got %0d expected 8", b0.level); end
                vecs++; if (b0.overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b expected 1", b0.overflow); end
                vecs++; if (b0.out_data !== sample_t'(-128)) begin errs++; $display("FAIL ovf_head got %0d expected -128", b0.out_data); end
            end
            for (int j = 0; j < 3; j++) begin
                drv0(1'b1, sample_t'(7), 1'b0, 1'b0);
                tick();
            end
        end
        drv0(1'b0, '0, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            vecs++; if (b0.out_valid !== 1'b1) begin errs++; $display("FAIL ovf_drain_valid j=%0d got %b expected 1", j, b0.out_valid); end
            vecs++; if (b0.out_data !== sample_t'(j - 128)) begin errs++; $display("FAIL ovf_drain_data j=%0d got %0d expected %0d", j, b0.out_data, j - 128); end
            tick();
        end
        vecs++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL ovf_empty got %b expected 0", b0.out_valid); end
        vecs++; if (b0.out_data !== sample_t'(-121)) begin errs++; $display("FAIL ovf_last_popped got %0d expected -121", b0.out_data); end
        vecs++; if (b0.overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b expected 1", b0.overflow); end
        drv0(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Full FIFO, kept sample arrives while the head is popped: accepted, no overflow
    task automatic test_full_push_pop();
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 4; p++) begin
                drv2(1'b1, (p == 2) ? sample_t'(10 + k) : sample_t'(99), 1'b0, 1'b0);
                tick();
            end
        end
        vecs++; if (b2.level !== LW'(8)) begin errs++; $display("FAIL fpp_fill got %0d expected 8", b2.level); end
        vecs++; if (b2.out_data !== sample_t'(10)) begin errs++; $display("FAIL fpp_head0 got %0d expected 10", b2.out_data); end
        for (int p = 0; p < 4; p++) begin
            drv2(1'b1, (p == 2) ? sample_t'(18) : sample_t'(99), p == 2, 1'b0);
            tick();
        end
        vecs++; if (b2.level !== LW'(8)) begin errs++; $display("FAIL fpp_level got %0d expected 8", b2.level); end
        vecs++; if (b2.overflow !== 1'b0) begin errs++; $display("FAIL fpp_overflow got %b expected 0", b2.overflow); end
        vecs++; if (b2.out_data !== sample_t'(11)) begin errs++; $display("FAIL fpp_head1 got %0d expected 11", b2.out_data); end
        drv2(1'b0, '0, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            vecs++; if (b2.out_data !== sample_t'(11 + j)) begin errs++; $display("FAIL fpp_order j=%0d got %0d expected %0d", j, b2.out_data, 11 + j); end
            tick();
        end
        vecs++; if (b2.level !== LW'(0)) begin errs++; $display("FAIL fpp_drained got %0d expected 0", b2.level); end
        drv2(1'b0, '0, 1'b0, 1'b0);
    endtask

    // clear beats a same-cycle kept sample and restarts the phase
    task automatic test_clear();
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 4; p++) begin
                drv0(1'b1, (p == 0) ? sample_t'(k + 1) : sample_t'(99), 1'b0, 1'b0);
                tick();
            end
        end
        vecs++; if (b0.level !== LW'(5)) begin errs++; $display("FAIL clr_pre_level got %0d expected 5", b0.level); end
        vecs++; if (b0.overflow !== 1'b1) begin errs++; $display("FAIL clr_pre_overflow got %b expected 1", b0.overflow); end
        drv0(1'b1, sample_t'(77), 1'b0, 1'b1);
        tick();
        vecs++; if (b0.level !== LW'(0)) begin errs++; $display("FAIL clr_level got %0d expected 0", b0.level); end
        vecs++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL clr_valid got %b expected 0", b0.out_valid); end
        vecs++; if (b0.overflow !== 1'b0) begin errs++; $display("FAIL clr_overflow got %b expected 0", b0.overflow); end
        drv0(1'b1, sample_t'(55), 1'b0, 1'b0);
        tick();
        vecs++; if (b0.out_data !== sample_t'(55)) begin errs++; $display("FAIL clr_first got %0d expected 55", b0.out_data); end
        vecs++; if (b0.level !== LW'(1)) begin errs++; $display("FAIL clr_first_level got %0d expected 1", b0.level); end
        drv0(1'b1, sample_t'(99), 1'b0, 1'b0);
        tick();
        drv0(1'b1, sample_t'(88), 1'b0, 1'b1);
        tick();
        vecs++; if (b0.level !== LW'(0)) begin errs++; $display("FAIL clr2_level got %0d expected 0", b0.level); end
        drv0(1'b1, sample_t'(66), 1'b0, 1'b0);
        tick();
        vecs++; if (b0.out_valid !== 1'b1) begin errs++; $display("FAIL clr2_phase_valid got %b expected 1", b0.out_valid); end
        vecs++; if (b0.out_data !== sample_t'(66)) begin errs++; $display("FAIL clr2_phase_data got %0d expected 66", b0.out_data); end
        drv0(1'b0, '0, 1'b0, 1'b1);
        tick();
        drv0(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Async reset mid-burst with level=3 and phase=2; stream restarts at phase 0
    task automatic test_async_reset();
        for (int c = 0; c < 10; c++) begin
            drv0(1'b1, (c % 4 == 0) ? sample_t'(31 + c / 4) : sample_t'(99), 1'b0, 1'b0);
            tick();
        end
        vecs++; if (b0.level !== LW'(3)) begin errs++; $display("FAIL ar_pre_level got %0d expected 3", b0.level); end
        drv0(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_b = 1'b0;
        #1;
        vecs++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL ar_valid got %b expected 0", b0.out_valid); end
        vecs++; if (b0.level !== LW'(0)) begin errs++; $display("FAIL ar_level got %0d expected 0", b0.level); end
        vecs++; if (b0.out_data !== sample_t'(0)) begin errs++; $display("FAIL ar_data got %0d expected 0", b0.out_data); end
        vecs++; if (b0.overflow !== 1'b0) begin errs++; $display("FAIL ar_overflow got %b expected 0", b0.overflow); end
        tick();
        @(negedge clk);
        rst_b = 1'b1;
        drv0(1'b1, sample_t'(40), 1'b0, 1'b0);
        tick();
        vecs++; if (b0.out_valid !== 1'b1) begin errs++; $display("FAIL ar_restart_valid got %b expected 1", b0.out_valid); end
        vecs++; if (b0.out_data !== sample_t'(40)) begin errs++; $display("FAIL ar_restart_data got %0d expected 40", b0.out_data); end
        vecs++; if (b0.level !== LW'(1)) begin errs++; $display("FAIL ar_restart_level got %0d expected 1", b0.level); end
        drv0(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_decimate();
        test_sparse_en();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
